// File: rtl/debug_master.sv
// debug_master: serial debug-link master. Drives a full-duplex bit-serial link
// (debug_clk/debug_cs/debug_di/debug_do). It sends one queued command byte or a Nop
// in every byte slot, and parses the returned byte stream into
// header/length/payload messages.
//
// Command handshake: a byte moves into the one-entry holding register on any
// rising clk edge where cmd_valid && cmd_ready. cmd_ready is low while the
// register is full. The register empties at the next byte start, when its
// contents go into the transmit shifter.
module debug_master #(
  parameter int ClkDivider = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       msg_start,
  output logic [7:0] msg_type,
  output logic [7:0] msg_len,
  output logic [7:0] msg_data,
  output logic       msg_data_valid,
  output logic       msg_done,
  output logic       sync_err,
  output logic       debug_clk,
  output logic       debug_cs,
  output logic       debug_di,
  input  logic       debug_do,
  output logic [1:0] dbg_link_state,
  output logic [1:0] dbg_parse_state
);

  localparam logic [7:0] HalfLast = 8'(ClkDivider - 1);

  typedef enum logic [1:0] {L_IDLE, L_SETUP, L_XFER, L_STOP} link_t;
  typedef enum logic [1:0] {P_HDR, P_LEN, P_PAYLOAD, P_NOPLEN} parse_t;

  link_t       r_link, w_link_nxt;
  parse_t      r_parse, w_parse_nxt;
  logic [7:0]  r_half_cnt;
  logic        r_sclk;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_tx_sh;
  logic [6:0]  r_rx_sh;
  logic        r_hold_full;
  logic [7:0]  r_hold_data;

  logic [7:0]  r_rem, r_type, r_len, r_data;
  logic        r_start, r_dv, r_done, r_err;
  logic [7:0]  w_rem_nxt, w_type_nxt, w_len_nxt, w_data_nxt;
  logic        w_start_nxt, w_dv_nxt, w_done_nxt, w_err_nxt;

  logic        w_half_end, w_rise, w_fall, w_byte_start, w_byte_done, w_stop;
  logic        w_accept;
  logic [7:0]  w_rx_byte;

  assign w_half_end = (r_half_cnt == HalfLast);
  assign w_accept   = cmd_valid && !r_hold_full;
  // The eighth sample is taken live, so a complete byte is visible on the fall.
  assign w_rx_byte  = {r_rx_sh, debug_do};
  assign w_stop     = w_byte_done && !en;

  // Link state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_link <= L_IDLE;
    else     r_link <= w_link_nxt;
  end

  // Link next state plus the clock-edge and byte-boundary strobes.
  always_comb begin
    w_link_nxt   = r_link;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_byte_start = 1'b0;
    w_byte_done  = 1'b0;
    case (r_link)
      L_IDLE: begin
        if (en) begin
          w_link_nxt   = L_SETUP;
          w_byte_start = 1'b1;
        end
      end
      L_SETUP: begin
        if (w_half_end) begin
          w_link_nxt = L_XFER;
          w_rise     = 1'b1;
        end
      end
      L_XFER: begin
        if (w_half_end) begin
          if (!r_sclk) begin
            w_rise = 1'b1;
          end else begin
            w_fall = 1'b1;
            if (r_bit_cnt == 3'd7) begin
              w_byte_done = 1'b1;
              if (en) w_byte_start = 1'b1;
              else    w_link_nxt   = L_STOP;
            end
          end
        end
      end
      L_STOP: begin
        if (w_half_end) w_link_nxt = L_IDLE;
      end
      default: w_link_nxt = L_IDLE;
    endcase
  end

  // Half-period timer, serial clock, bit counter, shifters and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half_cnt  <= 8'd0;
      r_sclk      <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_tx_sh     <= 8'd0;
      r_rx_sh     <= 7'd0;
      r_hold_full <= 1'b0;
      r_hold_data <= 8'd0;
    end else begin
      if (r_link == L_IDLE || w_half_end) r_half_cnt <= 8'd0;
      else                                r_half_cnt <= r_half_cnt + 8'd1;

      if (w_rise)      r_sclk <= 1'b1;
      else if (w_fall) r_sclk <= 1'b0;

      if (w_byte_start) r_bit_cnt <= 3'd0;
      else if (w_fall)  r_bit_cnt <= r_bit_cnt + 3'd1;

      // After eight shifts the register is all zeros, so debug_di idles low on stop.
      if (w_byte_start) r_tx_sh <= r_hold_full ? r_hold_data : 8'h00;
      else if (w_fall)  r_tx_sh <= {r_tx_sh[6:0], 1'b0};

      if (w_fall) r_rx_sh <= {r_rx_sh[5:0], debug_do};

      // A full register cannot accept, so load and accept never collide.
      if (w_byte_start && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_data <= cmd_data;
      end
    end
  end

  // Parser state and message output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parse <= P_HDR;
      r_rem   <= 8'd0;
      r_type  <= 8'd0;
      r_len   <= 8'd0;
      r_data  <= 8'd0;
      r_start <= 1'b0;
      r_dv    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_parse <= w_parse_nxt;
      r_rem   <= w_rem_nxt;
      r_type  <= w_type_nxt;
      r_len   <= w_len_nxt;
      r_data  <= w_data_nxt;
      r_start <= w_start_nxt;
      r_dv    <= w_dv_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Parser next state: decodes each completed byte. Leaving XFER forces HDR.
  always_comb begin
    w_parse_nxt = r_parse;
    w_rem_nxt   = r_rem;
    w_type_nxt  = r_type;
    w_len_nxt   = r_len;
    w_data_nxt  = r_data;
    w_start_nxt = 1'b0;
    w_dv_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    if (w_byte_done) begin
      case (r_parse)
        P_HDR: begin
          if (w_rx_byte == 8'h00) begin
            w_parse_nxt = P_NOPLEN;
          end else begin
            w_type_nxt  = w_rx_byte;
            w_parse_nxt = P_LEN;
          end
        end
        P_NOPLEN: begin
          if (w_rx_byte != 8'h00) w_err_nxt = 1'b1;
          w_parse_nxt = P_HDR;
        end
        P_LEN: begin
          w_len_nxt   = w_rx_byte;
          w_rem_nxt   = w_rx_byte;
          w_start_nxt = 1'b1;
          if (w_rx_byte == 8'h00) begin
            w_done_nxt  = 1'b1;
            w_parse_nxt = P_HDR;
          end else begin
            w_parse_nxt = P_PAYLOAD;
          end
        end
        P_PAYLOAD: begin
          w_data_nxt = w_rx_byte;
          w_dv_nxt   = 1'b1;
          w_rem_nxt  = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_done_nxt  = 1'b1;
            w_parse_nxt = P_HDR;
          end
        end
        default: w_parse_nxt = P_HDR;
      endcase
      if (w_stop) w_parse_nxt = P_HDR;
    end
  end

  assign cmd_ready       = !r_hold_full;
  assign debug_clk       = r_sclk;
  assign debug_cs        = (r_link == L_SETUP) || (r_link == L_XFER);
  assign debug_di        = r_tx_sh[7];
  assign msg_start       = r_start;
  assign msg_type        = r_type;
  assign msg_len         = r_len;
  assign msg_data        = r_data;
  assign msg_data_valid  = r_dv;
  assign msg_done        = r_done;
  assign sync_err        = r_err;
  assign dbg_link_state  = r_link;
  assign dbg_parse_state = r_parse;

endmodule

// File: tb/tb_debug_master.sv
// tb_debug_master: directed bench with a target model on the serial side and a
// scoreboard queue of expected message events checked by a monitor.
module tb_debug_master;

  localparam int CLKDIV = 4;
  localparam int BYTE_CYC = 16 * CLKDIV;
  localparam int W = 20;

  logic       clk, rst, en, cmd_valid, debug_do;
  logic [7:0] cmd_data;
  logic       cmd_ready, msg_start, msg_data_valid, msg_done, sync_err;
  logic [7:0] msg_type, msg_len, msg_data;
  logic       debug_clk, debug_cs, debug_di;
  logic [1:0] dbg_link_state, dbg_parse_state;

  logic [W-1:0] exp_q[$];
  logic [7:0]   cmd_q[$];
  logic [7:0]   tgt_q[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  debug_master #(.ClkDivider(CLKDIV)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .msg_start(msg_start), .msg_type(msg_type), .msg_len(msg_len),
    .msg_data(msg_data), .msg_data_valid(msg_data_valid), .msg_done(msg_done),
    .sync_err(sync_err), .debug_clk(debug_clk), .debug_cs(debug_cs),
    .debug_di(debug_di), .debug_do(debug_do),
    .dbg_link_state(dbg_link_state), .dbg_parse_state(dbg_parse_state)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ev_start(input logic [7:0] t, input logic [7:0] l);
    return {1'b1, 1'b0, (l == 8'h00), 1'b0, t, l};
  endfunction

  function automatic logic [W-1:0] ev_data(input logic [7:0] d, input logic last);
    return {1'b0, 1'b1, last, 1'b0, 8'h00, d};
  endfunction

  // Target model: sends bytes from tgt_q (Nop pairs when empty), captures debug_di, times debug_clk.
  initial begin
    int t_bit;
    int last_rise;
    logic [7:0] t_byte;
    logic [7:0] di_sh;
    logic prev_sclk;
    t_bit = 0; last_rise = -1; t_byte = 8'h00; di_sh = 8'h00; prev_sclk = 1'b0;
    debug_do = 1'b0;
    forever begin
      @(negedge clk);
      if (!debug_cs) begin
        t_bit = 0;
        last_rise = -1;
        prev_sclk = 1'b0;
        debug_do = 1'b0;
      end else begin
        if (debug_clk && !prev_sclk) begin
          if (last_rise >= 0) check("sclk_period", cyc - last_rise, 2 * CLKDIV);
          last_rise = cyc;
          if (t_bit == 0) begin
            if (tgt_q.size() == 0) begin
              tgt_q.push_back(8'h00);
              tgt_q.push_back(8'h00);
            end
            t_byte = tgt_q.pop_front();
          end
          debug_do = t_byte[7 - t_bit];
          di_sh = {di_sh[6:0], debug_di};
          t_bit++;
          if (t_bit == 8) begin
            t_bit = 0;
            if (di_sh != 8'h00) begin
              if (cmd_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL di_unexpected: got %0h expected 0", di_sh);
              end else begin
                check("di_byte", di_sh, cmd_q.pop_front());
              end
            end
          end
        end else if (!debug_clk && prev_sclk) begin
          check("sclk_high", cyc - last_rise, CLKDIV);
        end
        prev_sclk = debug_clk;
      end
    end
  end

  // Monitor: compares every message pulse against the scoreboard queue.
  initial begin
    logic [W-1:0] act;
    forever begin
      @(negedge clk);
      if (msg_start || msg_data_valid || msg_done) begin
        act = {msg_start, msg_data_valid, msg_done, 1'b0,
               msg_start ? msg_type : 8'h00, msg_start ? msg_len : msg_data};
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL msg_unexpected: got %0h expected none", act);
        end else begin
          check("msg_event", act, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b, input bit expect_sent);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 4 * BYTE_CYC) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_data = b;
    cmd_valid = 1'b1;
    if (expect_sent) cmd_q.push_back(b);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_ready_fall", cmd_ready, 0);
  endtask

  task automatic wait_exp_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("exp_drain", exp_q.size(), 0);
  endtask

  task automatic wait_tgt_empty(input int budget);
    int n;
    n = 0;
    while (tgt_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tgt_drain", tgt_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clk"}, debug_clk, 0);
    check({tag, "_cs"}, debug_cs, 0);
    check({tag, "_di"}, debug_di, 0);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_pulses"}, {msg_start, msg_data_valid, msg_done}, 0);
    check({tag, "_fields"}, {msg_type, msg_len, msg_data}, 0);
    check({tag, "_sync_err"}, sync_err, 0);
    check({tag, "_states"}, {dbg_link_state, dbg_parse_state}, 0);
  endtask

  // Directed stimulus sequence.
  initial begin
    int n;
    rst = 1'b1; en = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Idle link: Nop traffic only, no messages, no sync error.
    rst = 1'b0; en = 1'b1;
    repeat (4 * BYTE_CYC) @(negedge clk);
    check("idle_cs", debug_cs, 1);
    check("idle_sync_err", sync_err, 0);

    // One command goes out MSB first in the next byte slot.
    send_cmd(8'h81, 1'b1);
    n = 0;
    while (!cmd_ready && n < 2 * BYTE_CYC) begin @(negedge clk); n++; end
    check("cmd_ready_rise", cmd_ready, 1);
    n = 0;
    while (cmd_q.size() != 0 && n < 3 * BYTE_CYC) begin @(negedge clk); n++; end
    check("cmd_sent", cmd_q.size(), 0);

    // Message 0x81 len 2: 0xAA, 0x55.
    tgt_q.push_back(8'h81); tgt_q.push_back(8'h02);
    tgt_q.push_back(8'hAA); tgt_q.push_back(8'h55);
    exp_q.push_back(ev_start(8'h81, 8'h02));
    exp_q.push_back(ev_data(8'hAA, 1'b0));
    exp_q.push_back(ev_data(8'h55, 1'b1));
    wait_exp_empty(8 * BYTE_CYC);
    repeat (4) @(negedge clk);
    check("hold_fields", {msg_type, msg_len, msg_data}, 24'h81_02_55);

    // Nop header with non-zero length raises sticky sync_err; parsing continues.
    tgt_q.push_back(8'h00); tgt_q.push_back(8'h05);
    wait_tgt_empty(4 * BYTE_CYC);
    repeat (2 * BYTE_CYC) @(negedge clk);
    check("sync_err_set", sync_err, 1);
    tgt_q.push_back(8'h42); tgt_q.push_back(8'h01); tgt_q.push_back(8'h99);
    exp_q.push_back(ev_start(8'h42, 8'h01));
    exp_q.push_back(ev_data(8'h99, 1'b1));
    wait_exp_empty(6 * BYTE_CYC);
    check("sync_err_sticky", sync_err, 1);

    // Maximum-length message: 255 payload bytes.
    tgt_q.push_back(8'h7E); tgt_q.push_back(8'hFF);
    exp_q.push_back(ev_start(8'h7E, 8'hFF));
    for (int i = 0; i < 255; i++) begin
      tgt_q.push_back(8'(i));
      exp_q.push_back(ev_data(8'(i), i == 254));
    end
    wait_exp_empty(260 * BYTE_CYC);
    repeat (2) @(negedge clk);
    check("max_fields", {msg_len, msg_data}, 16'hFF_FE);

    // Disable mid-byte after a lone Nop header: cs holds until byte end, parser restarts.
    tgt_q.push_back(8'h00);
    wait_tgt_empty(4 * BYTE_CYC);
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (40) @(negedge clk);
    check("cs_hold_after_en_low", debug_cs, 1);
    n = 0;
    while (debug_cs && n < 40) begin @(negedge clk); n++; end
    check("cs_drop_at_boundary", debug_cs, 0);
    repeat (2 * CLKDIV + 4) @(negedge clk);
    check("stopped_idle", {debug_cs, debug_clk, dbg_link_state}, 0);
    tgt_q.push_back(8'h80); tgt_q.push_back(8'h00);
    exp_q.push_back(ev_start(8'h80, 8'h00));
    en = 1'b1;
    wait_exp_empty(6 * BYTE_CYC);

    // Reset mid-payload with a command held: everything clears, command is lost.
    tgt_q.push_back(8'h33); tgt_q.push_back(8'h04);
    tgt_q.push_back(8'h01); tgt_q.push_back(8'h02);
    tgt_q.push_back(8'h03); tgt_q.push_back(8'h04);
    exp_q.push_back(ev_start(8'h33, 8'h04));
    exp_q.push_back(ev_data(8'h01, 1'b0));
    exp_q.push_back(ev_data(8'h02, 1'b0));
    exp_q.push_back(ev_data(8'h03, 1'b0));
    exp_q.push_back(ev_data(8'h04, 1'b1));
    n = 0;
    while (!msg_data_valid && n < 8 * BYTE_CYC) begin @(negedge clk); n++; end
    check("first_payload_seen", msg_data_valid, 1);
    send_cmd(8'h5A, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    tgt_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    tgt_q.push_back(8'h44); tgt_q.push_back(8'h00);
    exp_q.push_back(ev_start(8'h44, 8'h00));
    rst = 1'b0;
    wait_exp_empty(6 * BYTE_CYC);
    check("post_rst_sync_err", sync_err, 0);

    // Drain and final bookkeeping.
    repeat (2 * BYTE_CYC) @(negedge clk);
    check("final_exp_q", exp_q.size(), 0);
    check("final_cmd_q", cmd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
